// File: rtl/sevenseg_pkg.sv
// Shared types and segment codes for the seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}, active low.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001111;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0001100;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

endpackage

// File: rtl/sevenseg_scan_hex7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with per-frame input
// snapshot, inter-digit blanking, digit enables and leading-zero blanking.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   an,
    output seg_t                    segs,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    first_q, first_d;
    logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
    logic                    lz_sh_q, lz_sh_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg_t                    segs_q, segs_d;
    logic                    dp_q, dp_d;
    logic                    fs_q, fs_d;

    logic                    slot_end;
    logic                    wrap;
    logic                    capture;
    phase_e                  phase;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    run;
    logic [3:0]              nib;
    seg_t                    dec_seg;

    assign nib = data_sh_q[{idx_q, 2'b00} +: 4];

    hex7_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // Counters and frame snapshot; the first edge out of reset only captures.
    always_comb begin
        slot_end  = (cnt_q == CW'(DIGIT_CYCLES - 1));
        wrap      = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
        capture   = first_q || wrap;
        first_d   = 1'b0;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_sh_d = data_sh_q;
        dp_sh_d   = dp_sh_q;
        en_sh_d   = en_sh_q;
        lz_sh_d   = lz_sh_q;
        if (first_q) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (capture) begin
            data_sh_d = data;
            dp_sh_d   = dp_in;
            en_sh_d   = digit_en;
            lz_sh_d   = lz_suppress;
        end
    end

    // Zero run from the most significant digit; digit 0 always shows.
    always_comb begin
        supp = '0;
        run  = lz_sh_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run     = run && (data_sh_q[4*i +: 4] == 4'h0);
            supp[i] = run;
        end
    end

    // A suppressed digit only lights its anode when it must show its dp.
    always_comb begin
        phase  = (cnt_q < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
        an_d   = '1;
        segs_d = SEG_BLANK;
        dp_d   = 1'b1;
        fs_d   = capture;
        if (phase == PH_SHOW && en_sh_q[idx_q]) begin
            if (!supp[idx_q] || dp_sh_q[idx_q]) begin
                an_d[idx_q] = 1'b0;
            end
            segs_d = supp[idx_q] ? SEG_BLANK : dec_seg;
            dp_d   = ~dp_sh_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            first_q   <= 1'b1;
            data_sh_q <= '0;
            dp_sh_q   <= '0;
            en_sh_q   <= '0;
            lz_sh_q   <= 1'b0;
            an_q      <= '1;
            segs_q    <= SEG_BLANK;
            dp_q      <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            data_sh_q <= data_sh_d;
            dp_sh_q   <= dp_sh_d;
            en_sh_q   <= en_sh_d;
            lz_sh_q   <= lz_sh_d;
            an_q      <= an_d;
            segs_q    <= segs_d;
            dp_q      <= dp_d;
            fs_q      <= fs_d;
        end
    end

    assign an          = an_q;
    assign segs        = segs_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with 4 digits, 8-cycle slots, 2 blank.
// Outputs are sampled on the falling edge.
module tb_sevenseg_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic [3:0]  an;
    logic [6:0]  segs;
    logic        dp;
    logic        frame_start;

    int checks;
    int errors;

    logic       exp_lit [4];
    logic [6:0] exp_seg [4];
    logic       exp_dpo [4];

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] SB = 7'b1111111;

    sevenseg_scan #(
        .NUM_DIGITS   (4),
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data        (data),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .an          (an),
        .segs        (segs),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL onehot an=%b required at most one low", an);
        end
    end

    // Expected {frame_start, an, segs, dp} for cycle t (1..32) after a frame_start.
    function automatic logic [12:0] exp_vec(int t);
        int         k;
        int         c;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        k = (t - 1) / 8;
        c = (t - 1) % 8;
        a = 4'hF;
        s = SB;
        d = 1'b1;
        if (c >= 2) begin
            if (exp_lit[k]) a[k] = 1'b0;
            s = exp_seg[k];
            d = exp_dpo[k];
        end
        return {(t == 32), a, s, d};
    endfunction

    task automatic set_exp(int k, logic lit, logic [6:0] s, logic d);
        exp_lit[k] = lit;
        exp_seg[k] = s;
        exp_dpo[k] = d;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 40);
    endtask

    task automatic test_reset();
        int n;
        rst_n       = 1'b0;
        data        = 16'h12AF;
        dp_in       = 4'h0;
        digit_en    = 4'hF;
        lz_suppress = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({frame_start, an, segs, dp} !== {1'b0, 4'hF, SB, 1'b1}) begin
                errors++;
                $display("FAIL reset got %b required %b",
                         {frame_start, an, segs, dp}, {1'b0, 4'hF, SB, 1'b1});
            end
        end
        rst_n = 1'b1;
        wait_fs(n);
        checks++;
        if (frame_start !== 1'b1 || n != 1) begin
            errors++;
            $display("FAIL reset_fs cycles=%0d fs=%b required 1 and 1", n, frame_start);
        end
    endtask

    task automatic test_hex();
        set_exp(0, 1'b1, SF, 1'b1);
        set_exp(1, 1'b1, SA, 1'b1);
        set_exp(2, 1'b1, S2, 1'b1);
        set_exp(3, 1'b1, S1, 1'b1);
        repeat (2) begin
            for (int t = 1; t <= 32; t++) begin
                @(negedge clk);
                checks++;
                if ({frame_start, an, segs, dp} !== exp_vec(t)) begin
                    errors++;
                    $display("FAIL hex t=%0d got %b required %b",
                             t, {frame_start, an, segs, dp}, exp_vec(t));
                end
            end
        end
    endtask

    task automatic test_lz();
        int n;
        data        = 16'h0070;
        lz_suppress = 1'b1;
        set_exp(0, 1'b1, S0, 1'b1);
        set_exp(1, 1'b1, S7, 1'b1);
        set_exp(2, 1'b0, SB, 1'b1);
        set_exp(3, 1'b0, SB, 1'b1);
        wait_fs(n);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL lz_wait timeout fs=%b required 1", frame_start);
        end
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            checks++;
            if ({frame_start, an, segs, dp} !== exp_vec(t)) begin
                errors++;
                $display("FAIL lz t=%0d got %b required %b",
                         t, {frame_start, an, segs, dp}, exp_vec(t));
            end
        end
    endtask

    task automatic test_dp_suppress();
        int n;
        data  = 16'h0000;
        dp_in = 4'b0100;
        set_exp(0, 1'b1, S0, 1'b1);
        set_exp(1, 1'b0, SB, 1'b1);
        set_exp(2, 1'b1, SB, 1'b0);
        set_exp(3, 1'b0, SB, 1'b1);
        wait_fs(n);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL dp_wait timeout fs=%b required 1", frame_start);
        end
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            checks++;
            if ({frame_start, an, segs, dp} !== exp_vec(t)) begin
                errors++;
                $display("FAIL dp_supp t=%0d got %b required %b",
                         t, {frame_start, an, segs, dp}, exp_vec(t));
            end
        end
    endtask

    task automatic test_midframe();
        int n;
        data        = 16'h1111;
        dp_in       = 4'h0;
        lz_suppress = 1'b0;
        for (int k = 0; k < 4; k++) set_exp(k, 1'b1, S1, 1'b1);
        wait_fs(n);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait timeout fs=%b required 1", frame_start);
        end
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            if (t == 17) data = 16'h2222;
            checks++;
            if ({frame_start, an, segs, dp} !== exp_vec(t)) begin
                errors++;
                $display("FAIL mid_old t=%0d got %b required %b",
                         t, {frame_start, an, segs, dp}, exp_vec(t));
            end
        end
        for (int k = 0; k < 4; k++) set_exp(k, 1'b1, S2, 1'b1);
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            checks++;
            if ({frame_start, an, segs, dp} !== exp_vec(t)) begin
                errors++;
                $display("FAIL mid_new t=%0d got %b required %b",
                         t, {frame_start, an, segs, dp}, exp_vec(t));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int t = 1; t <= 20; t++) @(negedge clk);
        checks++;
        if ({frame_start, an, segs, dp} !== exp_vec(20)) begin
            errors++;
            $display("FAIL rmid_pre got %b required %b",
                     {frame_start, an, segs, dp}, exp_vec(20));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({frame_start, an, segs, dp} !== {1'b0, 4'hF, SB, 1'b1}) begin
            errors++;
            $display("FAIL rmid_async got %b required %b",
                     {frame_start, an, segs, dp}, {1'b0, 4'hF, SB, 1'b1});
        end
        @(negedge clk);
        checks++;
        if ({frame_start, an, segs, dp} !== {1'b0, 4'hF, SB, 1'b1}) begin
            errors++;
            $display("FAIL rmid_hold got %b required %b",
                     {frame_start, an, segs, dp}, {1'b0, 4'hF, SB, 1'b1});
        end
        rst_n = 1'b1;
        wait_fs(n);
        checks++;
        if (frame_start !== 1'b1 || n != 1) begin
            errors++;
            $display("FAIL rmid_fs cycles=%0d fs=%b required 1 and 1", n, frame_start);
        end
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            checks++;
            if ({frame_start, an, segs, dp} !== exp_vec(t)) begin
                errors++;
                $display("FAIL rmid t=%0d got %b required %b",
                         t, {frame_start, an, segs, dp}, exp_vec(t));
            end
        end
    endtask

    task automatic test_enable();
        int n;
        data     = 16'h12AF;
        digit_en = 4'b0101;
        set_exp(0, 1'b1, SF, 1'b1);
        set_exp(1, 1'b0, SB, 1'b1);
        set_exp(2, 1'b1, S2, 1'b1);
        set_exp(3, 1'b0, SB, 1'b1);
        wait_fs(n);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL en_wait timeout fs=%b required 1", frame_start);
        end
        repeat (3) begin
            for (int t = 1; t <= 32; t++) begin
                @(negedge clk);
                checks++;
                if ({frame_start, an, segs, dp} !== exp_vec(t)) begin
                    errors++;
                    $display("FAIL enable t=%0d got %b required %b",
                             t, {frame_start, an, segs, dp}, exp_vec(t));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hex();
        test_lz();
        test_dp_suppress();
        test_midframe();
        test_reset_mid();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
